// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with fill count, thresholds, sticky errors and selectable read mode
//
// Purpose: same-clock FIFO. Pointers carry an extra wrap bit, so all
//          2**ADDR_WIDTH entries are usable.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   wr_en / din  in   write request / write data
//   rd_en        in   read request (FWFT=1: pop of the head word)
//   dout         out  read data
//   dout_valid   out  dout holds a valid word
//   full, empty  out  count == DEPTH / count == 0
//   almost_full  out  count >= AFULL_LEVEL
//   almost_empty out  count <= AEMPTY_LEVEL
//   count        out  stored words, 0..DEPTH
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
//   err_clr      in   clears overflow/underflow
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int AFULL_LEVEL  = (2 ** ADDR_WIDTH) - 4,
  parameter int AEMPTY_LEVEL = 4,
  parameter int FWFT         = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [ADDR_WIDTH:0]   w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wen;
  logic                  w_ren;

  // All flags decode from the registered pointers only.
  assign w_empty = (r_wptr == r_rptr);
  // Same slot, opposite lap: writer is exactly one lap ahead.
  assign w_full  = (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]) &&
                   (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);
  // Modulo subtraction yields 0..DEPTH thanks to the wrap bit.
  assign w_count = r_wptr - r_rptr;

  // Acceptance uses start-of-cycle flags; a same-cycle read never frees
  // room for a write, nor does a same-cycle write feed a read.
  assign w_wen = wr_en && !w_full  && !reset;
  assign w_ren = rd_en && !w_empty && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wen) r_wptr <= r_wptr + 1'b1;
      if (w_ren) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= din;
  end

  // Sticky errors: a new offence in the clearing cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)      r_overflow <= 1'b1;
      else if (err_clr)         r_overflow <= 1'b0;
      if (rd_en && w_empty)     r_underflow <= 1'b1;
      else if (err_clr)         r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_dout_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_dout       <= '0;
          r_dout_valid <= 1'b0;
        end else begin
          r_dout_valid <= w_ren;
          if (w_ren) r_dout <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
        end
      end

      assign dout       = r_dout;
      assign dout_valid = r_dout_valid;
    end else begin : g_fwft
      // Head word is always presented; rd_en acknowledges it.
      assign dout       = r_mem[r_rptr[ADDR_WIDTH-1:0]];
      assign dout_valid = !w_empty;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= C_AFULL);
  assign almost_empty = (w_count <= C_AEMPTY);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
